// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a word-organised memory.
// Address-window decode, fixed wait states and byte-lane masked writes.
module wb_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [3:0]            sel_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LOW_W = IDX_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;

    logic [ADDR_WIDTH-1:0] lat_adr;
    logic                  lat_we;
    logic [3:0]            lat_sel;
    logic [DATA_WIDTH-1:0] lat_dat;

    logic [ADDR_WIDTH-1:0] cur_adr;
    logic                  cur_we;
    logic [3:0]            cur_sel;
    logic [DATA_WIDTH-1:0] cur_dat;
    logic                  cur_hit;
    logic [IDX_W-1:0]      cur_idx;
    logic                  req;
    logic                  enter_resp;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign req = cyc_i & stb_i;

    // With zero wait states RESP is entered on the sample edge itself, so the
    // live bus request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        cur_adr = lat_adr;
        cur_we  = lat_we;
        cur_sel = lat_sel;
        cur_dat = lat_dat;
        if (state == S_IDLE) begin
            cur_adr = adr_i;
            cur_we  = we_i;
            cur_sel = sel_i;
            cur_dat = dat_i;
        end
        // The window is aligned to its own size, so a tag compare is exact.
        cur_hit = (cur_adr[1:0] == 2'b00) &&
                  (cur_adr[ADDR_WIDTH-1:LOW_W] == BASE_ADDR[ADDR_WIDTH-1:LOW_W]);
        cur_idx = cur_adr[LOW_W-1:2];
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    state_next    = S_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        enter_resp = (state_next == S_RESP) && (state != S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            lat_adr  <= '0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
            lat_dat  <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == S_IDLE && req) begin
                lat_adr <= adr_i;
                lat_we  <= we_i;
                lat_sel <= sel_i;
                lat_dat <= dat_i;
            end
            ack_o <= enter_resp & cur_hit;
            err_o <= enter_resp & ~cur_hit;
            dat_o <= (enter_resp && cur_hit && !cur_we) ? mem[cur_idx] : '0;
        end
    end

    // Contents survive reset; only the commit itself is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_hit && cur_we) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_sel[k]) mem[cur_idx][8*k +: 8] <= cur_dat[8*k +: 8];
            end
        end
    end
endmodule
